surface_normal_sequencer: RTL and testbench

Sequences one shared `sceneQuery` pipeline through the four tetrahedral SDF samples needed for a surface normal, replacing the four parallel `sceneQuery` instances. It accepts a hit point and light position with a valid/ready handshake and issues the four offset positions on consecutive cycles. It collects the four in-order distances and produces the unnormalised surface normal and light vector for the downstream `inv_sqrt` normalisation stage. All values are `fp` Q8.24 (1.0 = 32'h01000000); `vec3` is packed {x,y,z}, 96 bits.

---
 rtl/surface_normal_sequencer.sv | 148 ++++++++++++++
 tb/tb_surface_normal_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/surface_normal_sequencer.sv
// Time-multiplexes one sceneQuery pipeline over the four tetrahedral SDF samples
// of a surface normal and accumulates the unnormalised normal and light vector.
module surface_normal_sequencer #(
    parameter logic [31:0] EPS        = 32'h00004189,
    parameter int          SQ_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] in_p,
    input  logic [95:0] in_light_pos,
    output logic        sq_valid,
    output logic [95:0] sq_pos,
    input  logic        sq_result_valid,
    input  logic [31:0] sq_dist,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_normal,
    output logic [95:0] out_light_vec
);

    localparam int CW = (SQ_LATENCY < 2) ? 2 : $clog2(SQ_LATENCY + 1);

    // Bit k is set when component of tetrahedron vertex h_k is positive.
    localparam logic [3:0] SIGN_X = 4'b1001;
    localparam logic [3:0] SIGN_Y = 4'b1010;
    localparam logic [3:0] SIGN_Z = 4'b1100;

    typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] drainCnt_q;
    logic [1:0]    issueIdx_q;
    logic [2:0]    resCnt_q, resCnt_d;
    logic [95:0]   p_q;
    logic          sqValid_q;
    logic [95:0]   sqPos_q;
    logic [31:0]   accX_q, accY_q, accZ_q;
    logic [31:0]   accX_d, accY_d, accZ_d;
    logic [95:0]   lightVec_q;
    logic          resTake;

    function automatic logic [31:0] offsetComp(input logic [31:0] v, input logic plus);
        return plus ? v + EPS : v - EPS;
    endfunction

    function automatic logic [95:0] samplePos(input logic [95:0] p, input logic [1:0] k);
        return {offsetComp(p[95:64], SIGN_X[k]),
                offsetComp(p[63:32], SIGN_Y[k]),
                offsetComp(p[31:0],  SIGN_Z[k])};
    endfunction

    function automatic logic [31:0] signedAdd(input logic [31:0] acc, input logic plus,
                                              input logic [31:0] d);
        return plus ? acc + d : acc - d;
    endfunction

    // Results are only meaningful while a job is in flight; anything else is stale.
    always_comb begin
        resTake  = sq_result_valid && (state_q == S_ISSUE || state_q == S_WAIT)
                   && (resCnt_q != 3'd4);
        resCnt_d = resCnt_q;
        accX_d   = accX_q;
        accY_d   = accY_q;
        accZ_d   = accZ_q;
        if (resTake) begin
            resCnt_d = resCnt_q + 3'd1;
            accX_d   = signedAdd(accX_q, SIGN_X[resCnt_q[1:0]], sq_dist);
            accY_d   = signedAdd(accY_q, SIGN_Y[resCnt_q[1:0]], sq_dist);
            accZ_d   = signedAdd(accZ_q, SIGN_Z[resCnt_q[1:0]], sq_dist);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_DRAIN;
            drainCnt_q <= CW'(SQ_LATENCY);
            issueIdx_q <= 2'd0;
            resCnt_q   <= 3'd0;
            p_q        <= '0;
            sqValid_q  <= 1'b0;
            sqPos_q    <= '0;
            accX_q     <= '0;
            accY_q     <= '0;
            accZ_q     <= '0;
            lightVec_q <= '0;
        end else begin
            resCnt_q <= resCnt_d;
            accX_q   <= accX_d;
            accY_q   <= accY_d;
            accZ_q   <= accZ_d;
            case (state_q)
                S_DRAIN: begin
                    if (drainCnt_q <= CW'(1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        drainCnt_q <= drainCnt_q - CW'(1);
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        p_q        <= in_p;
                        lightVec_q <= {in_light_pos[95:64] - in_p[95:64],
                                       in_light_pos[63:32] - in_p[63:32],
                                       in_light_pos[31:0]  - in_p[31:0]};
                        resCnt_q   <= 3'd0;
                        accX_q     <= '0;
                        accY_q     <= '0;
                        accZ_q     <= '0;
                        issueIdx_q <= 2'd0;
                        sqValid_q  <= 1'b1;
                        sqPos_q    <= samplePos(in_p, 2'd0);
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issueIdx_q == 2'd3) begin
                        sqValid_q <= 1'b0;
                        state_q   <= (resCnt_d == 3'd4) ? S_DONE : S_WAIT;
                    end else begin
                        issueIdx_q <= issueIdx_q + 2'd1;
                        sqPos_q    <= samplePos(p_q, issueIdx_q + 2'd1);
                    end
                end
                S_WAIT: begin
                    if (resCnt_d == 3'd4) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_DRAIN;
            endcase
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign sq_valid      = sqValid_q;
    assign sq_pos        = sqPos_q;
    assign out_normal    = {accX_q, accY_q, accZ_q};
    assign out_light_vec = lightVec_q;

endmodule

// File: tb/tb_surface_normal_sequencer.sv
// Randomised bench for surface_normal_sequencer: two instances (latency 3 and 1) share
// stimulus, each fed by a linear-SDF sceneQuery model and checked against a job-level model.
module tb_surface_normal_sequencer;

    localparam logic [31:0] EPS  = 32'h00004189;
    localparam int          LAT0 = 3;
    localparam int          LAT1 = 1;
    localparam int          BIG  = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid;
    logic [95:0] inP;
    logic [95:0] inLight;
    logic        outReady;
    logic [1:0]  inReady, sqValid, sqResValid, outValid;
    logic [95:0] sqPos [2];
    logic [31:0] sqDist [2];
    logic [95:0] outNormal [2];
    logic [95:0] outLight [2];

    always #5 clk = ~clk;

    surface_normal_sequencer #(.EPS(EPS), .SQ_LATENCY(LAT0)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady[0]),
        .in_p(inP), .in_light_pos(inLight),
        .sq_valid(sqValid[0]), .sq_pos(sqPos[0]),
        .sq_result_valid(sqResValid[0]), .sq_dist(sqDist[0]),
        .out_valid(outValid[0]), .out_ready(outReady),
        .out_normal(outNormal[0]), .out_light_vec(outLight[0])
    );

    surface_normal_sequencer #(.EPS(EPS), .SQ_LATENCY(LAT1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady[1]),
        .in_p(inP), .in_light_pos(inLight),
        .sq_valid(sqValid[1]), .sq_pos(sqPos[1]),
        .sq_result_valid(sqResValid[1]), .sq_dist(sqDist[1]),
        .out_valid(outValid[1]), .out_ready(outReady),
        .out_normal(outNormal[1]), .out_light_vec(outLight[1])
    );

    // Linear SDF d = x + 2y + 3z in 32-bit wrap-around arithmetic.
    function automatic logic [31:0] sdf(input logic [95:0] q);
        return q[95:64] + (q[63:32] << 1) + q[31:0] * 32'd3;
    endfunction

    // sceneQuery stand-ins: pure delay lines, deliberately unaffected by rst.
    logic        pipeV0 [LAT0];
    logic [31:0] pipeD0 [LAT0];
    logic        pipeV1 [LAT1];
    logic [31:0] pipeD1 [LAT1];

    always @(posedge clk) begin
        for (int i = LAT0 - 1; i > 0; i--) begin
            pipeV0[i] <= pipeV0[i-1];
            pipeD0[i] <= pipeD0[i-1];
        end
        pipeV0[0] <= sqValid[0];
        pipeD0[0] <= sdf(sqPos[0]);
    end

    always @(posedge clk) begin
        for (int i = LAT1 - 1; i > 0; i--) begin
            pipeV1[i] <= pipeV1[i-1];
            pipeD1[i] <= pipeD1[i-1];
        end
        pipeV1[0] <= sqValid[1];
        pipeD1[0] <= sdf(sqPos[1]);
    end

    assign sqResValid[0] = pipeV0[LAT0-1];
    assign sqDist[0]     = pipeD0[LAT0-1];
    assign sqResValid[1] = pipeV1[LAT1-1];
    assign sqDist[1]     = pipeD1[LAT1-1];

    // Tetrahedron vertex h_k: x is + for k in {0,3}, y for {1,3}, z for {2,3}.
    function automatic logic [95:0] modelPos(input logic [95:0] p, input int k);
        int sx, sy, sz;
        sx = (k == 0 || k == 3) ? 1 : -1;
        sy = (k == 1 || k == 3) ? 1 : -1;
        sz = (k == 2 || k == 3) ? 1 : -1;
        return {p[95:64] + 32'(sx) * EPS, p[63:32] + 32'(sy) * EPS, p[31:0] + 32'(sz) * EPS};
    endfunction

    function automatic logic [95:0] modelNormal(input logic [95:0] p);
        logic [31:0] d0, d1, d2, d3;
        d0 = sdf(modelPos(p, 0));
        d1 = sdf(modelPos(p, 1));
        d2 = sdf(modelPos(p, 2));
        d3 = sdf(modelPos(p, 3));
        return {d0 - d1 - d2 + d3, d1 + d3 - d0 - d2, d2 + d3 - d0 - d1};
    endfunction

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          jobT [2];
    int          jobE [2];
    int          drainEnd [2];
    int          jobCount [2];
    int          kV [2];
    logic        fresh [2];
    logic        expRdy [2];
    logic        expOutV [2];
    logic [95:0] expPos [2][4];
    logic [95:0] expN [2];
    logic [95:0] expL [2];
    int          bpSeen = 0;
    logic        bpDone = 1'b0;
    logic        rstDone = 1'b0;
    int          rstReleaseAt = 2;
    logic        assertNow, releaseNow;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int d, input logic [95:0] act,
                               input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cyc, act, exp);
        end
    endtask

    task automatic checkCycle();
        int   lat;
        logic active, expSqV;
        for (int d = 0; d < 2; d++) begin
            lat        = (d == 0) ? LAT0 : LAT1;
            active     = (cyc >= jobT[d]) && (cyc < jobE[d]);
            kV[d]      = cyc - jobT[d];
            expRdy[d]  = !rst && (cyc >= drainEnd[d]) && !active;
            expSqV     = active && (kV[d] <= 3);
            expOutV[d] = active && (kV[d] >= lat + 4);
            checkOutput("in_ready", d, 96'(inReady[d]), 96'(expRdy[d]));
            checkOutput("sq_valid", d, 96'(sqValid[d]), 96'(expSqV));
            checkOutput("out_valid", d, 96'(outValid[d]), 96'(expOutV[d]));
            if (expSqV) begin
                checkOutput("sq_pos", d, sqPos[d], expPos[d][kV[d]]);
                if (jobCount[d] == 1 && kV[d] == 0)
                    checkOutput("sq_pos0_literal", d, sqPos[d], 96'h01004189_00FFBE77_00FFBE77);
            end
            if (expOutV[d]) begin
                checkOutput("out_normal", d, outNormal[d], expN[d]);
                checkOutput("out_light_vec", d, outLight[d], expL[d]);
                if (jobCount[d] == 1) begin
                    checkOutput("normal_literal", d, outNormal[d], 96'h00010624_00020C48_0003126C);
                    checkOutput("light_literal", d, outLight[d], 96'h01000000_FF000000_FF000000);
                end
            end
            if (d == 0 && jobCount[0] == 1 && active && kV[0] == 6)
                checkOutput("out_valid_before_7", d, 96'(outValid[0]), 96'd0);
            if (d == 0 && jobCount[0] == 1 && active && kV[0] == 7)
                checkOutput("out_valid_at_7", d, 96'(outValid[0]), 96'd1);
            if (fresh[d]) begin
                checkOutput("fresh_sq_pos", d, sqPos[d], 96'd0);
                checkOutput("fresh_normal", d, outNormal[d], 96'd0);
                checkOutput("fresh_light", d, outLight[d], 96'd0);
            end
        end
        if (!bpDone && expOutV[0] && jobCount[0] == 1) bpSeen++;
        if (cyc == 1200) checkOutput("mid_job_reset_reached", 0, 96'(rstDone), 96'd1);
    endtask

    task automatic applyStimulus();
        assertNow  = 1'b0;
        releaseNow = 1'b0;
        if (rst && cyc >= rstReleaseAt) begin
            rst        = 1'b0;
            releaseNow = 1'b1;
        end else if (!rstDone && cyc > 400 && jobT[0] >= 0 && kV[0] == 5) begin
            // DUT0 is waiting with two of its four results still in flight.
            rst          = 1'b1;
            assertNow    = 1'b1;
            rstDone      = 1'b1;
            rstReleaseAt = cyc + 1;
        end
        if (jobCount[0] == 0 || jobCount[1] == 0) begin
            inValid = 1'b1;
            inP     = {32'h01000000, 32'h01000000, 32'h01000000};
            inLight = {32'h02000000, 32'h00000000, 32'h00000000};
        end else begin
            inValid = 1'($urandom_range(0, 1));
            inP     = {$urandom, $urandom, $urandom};
            inLight = {$urandom, $urandom, $urandom};
        end
        if (!bpDone) begin
            inValid  = 1'b1;
            outReady = (bpSeen >= 10);
            if (bpSeen >= 10) bpDone = 1'b1;
        end else begin
            outReady = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic updateModel();
        for (int d = 0; d < 2; d++) begin
            if (assertNow) begin
                jobT[d]     = -1000;
                jobE[d]     = -1000;
                drainEnd[d] = BIG;
                fresh[d]    = 1'b1;
            end else if (releaseNow) begin
                drainEnd[d] = cyc + ((d == 0) ? LAT0 : LAT1);
            end else if (!rst) begin
                if (expRdy[d] && inValid) begin
                    jobT[d] = cyc + 1;
                    jobE[d] = BIG;
                    jobCount[d]++;
                    fresh[d] = 1'b0;
                    for (int k = 0; k < 4; k++) expPos[d][k] = modelPos(inP, k);
                    expN[d] = modelNormal(inP);
                    expL[d] = {inLight[95:64] - inP[95:64], inLight[63:32] - inP[63:32],
                               inLight[31:0] - inP[31:0]};
                end
                if (expOutV[d] && outReady) jobE[d] = cyc + 1;
            end
        end
    endtask

    initial begin
        inValid  = 1'b0;
        inP      = '0;
        inLight  = '0;
        outReady = 1'b0;
        for (int d = 0; d < 2; d++) begin
            jobT[d]     = -1000;
            jobE[d]     = -1000;
            drainEnd[d] = BIG;
            jobCount[d] = 0;
            fresh[d]    = 1'b1;
            kV[d]       = 0;
        end
        forever begin
            @(negedge clk);
            checkCycle();
            if (cyc >= 1600) begin
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            applyStimulus();
            updateModel();
        end
    end

endmodule
